avr_xmem_bridge: RTL

- Multi-window external data-memory bridge between the AVR core DM bus and up to NUM_WIN external byte-wide slaves (SRAM, ROM, peripheral register files).
- Each window has its own base, size and wait-state count, plus a per-slave wait input.
- Adds a bus timeout with a sticky error flag.
- Replaces the single fixed sram window, which has no wait-state counting and no timeout; sits beside the internal DM SRAM on the core's ramadr/ramre/ramwe bus.

---
 rtl/avr_xmem_bridge_if.sv | 33 +++
 rtl/avr_xmem_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/avr_xmem_bridge_if.sv
// External byte-wide slave bus between the XMEM bridge and its window slaves.
// The bridge is the master; slaves return read data and wait per window.
interface avr_xmem_bridge_if #(
  parameter int NUM_WIN = 2
);
  logic [15:0]          ext_a;
  logic [7:0]           ext_d_out;
  logic [8*NUM_WIN-1:0] ext_d_in;
  logic [NUM_WIN-1:0]   ext_cs;
  logic                 ext_oe;
  logic                 ext_we;
  logic [NUM_WIN-1:0]   ext_wait;

  modport master (
    output ext_a,
    output ext_d_out,
    output ext_cs,
    output ext_oe,
    output ext_we,
    input  ext_d_in,
    input  ext_wait
  );

  modport slave (
    input  ext_a,
    input  ext_d_out,
    input  ext_cs,
    input  ext_oe,
    input  ext_we,
    output ext_d_in,
    output ext_wait
  );
endinterface

// File: rtl/avr_xmem_bridge.sv
// Multi-window external data-memory bridge for the AVR DM bus.
// Decodes ramadr against NUM_WIN windows, runs one access at a time with
// fixed wait states plus slave wait, and aborts stuck slaves after a timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access; a hit with ramre/ramwe stalls the core and starts one
// ACCESS | chip select and strobe driven; wait states, then slave wait/timeout
// DONE   | single release cycle, core completes, ramdout holds the result
module avr_xmem_bridge #(
  parameter int                   NUM_WIN     = 2,
  parameter logic [16*NUM_WIN-1:0] WIN_BASE    = {16'hE000, 16'hC000},
  parameter logic [16*NUM_WIN-1:0] WIN_SIZE    = {16'h0400, 16'h1000},
  parameter logic [4*NUM_WIN-1:0]  WIN_WS      = {4'd0, 4'd3},
  parameter int                   TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [15:0]       ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic [7:0]        ramdin,
  output logic [7:0]        ramdout,
  output logic              out_en,
  output logic              cpuwait,
  avr_xmem_bridge_if.master ext,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int IDX_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Abort fires on the cycle the counter would reach TIMEOUT_CYC.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              req;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [3:0]        ws_hit;
  logic              accept;
  logic              finish;
  logic              abort;

  logic [15:0]       adr_q;
  logic [7:0]        dat_q;
  logic              dir_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        ws_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [7:0]        rdata_q;
  logic              err_q;

  logic [7:0]        rd_sel;
  logic              wait_sel;

  logic [NUM_WIN-1:0] cs;
  logic               oe;
  logic               we;
  logic               stall;

  assign req = ramre | ramwe;

  // Window decode in 17 bits so a window ending at 16'hFFFF is valid; the
  // downward loop makes the lowest index win on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if ((WIN_SIZE[16*i +: 16] != 16'd0) &&
          ({1'b0, ramadr} >= {1'b0, WIN_BASE[16*i +: 16]}) &&
          ({1'b0, ramadr} <  ({1'b0, WIN_BASE[16*i +: 16]} + {1'b0, WIN_SIZE[16*i +: 16]}))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Per-window lookups: wait states of the decoded window, data/wait of the latched one.
  always_comb begin
    ws_hit   = 4'd0;
    rd_sel   = 8'd0;
    wait_sel = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (IDX_W'(i) == hit_idx) ws_hit = WIN_WS[4*i +: 4];
      if (IDX_W'(i) == idx_q) begin
        rd_sel   = ext.ext_d_in[8*i +: 8];
        wait_sel = ext.ext_wait[i];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && req && hit;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; slave wait is only looked at once fixed wait states are spent.
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (ws_q == 4'd0) begin
          if (!wait_sel) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end else if ((TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST)) begin
            abort   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: strobes only in ACCESS, stall in the request cycle and ACCESS.
  always_comb begin
    cs    = '0;
    oe    = 1'b0;
    we    = 1'b0;
    stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = req & hit;
      end
      S_ACCESS: begin
        for (int i = 0; i < NUM_WIN; i++) cs[i] = (IDX_W'(i) == idx_q);
        oe    = ~dir_q;
        we    = dir_q;
        stall = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Request capture, wait-state countdown and timeout counting.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      adr_q    <= 16'd0;
      dat_q    <= 8'd0;
      dir_q    <= 1'b0;
      idx_q    <= '0;
      ws_q     <= 4'd0;
      to_cnt_q <= '0;
    end else if (accept) begin
      adr_q    <= ramadr;
      dat_q    <= ramdin;
      dir_q    <= ramwe;
      idx_q    <= hit_idx;
      ws_q     <= ws_hit;
      to_cnt_q <= '0;
    end else if (state_q == S_ACCESS) begin
      if (ws_q != 4'd0)  ws_q     <= ws_q - 4'd1;
      else if (wait_sel) to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Read data: slave byte on completion, 8'hFF on abort, back to 0 when leaving DONE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                   rdata_q <= 8'd0;
    else if (finish && !dir_q)   rdata_q <= rd_sel;
    else if (abort && !dir_q)    rdata_q <= 8'hFF;
    else if (state_q == S_DONE)  rdata_q <= 8'd0;
  end

  // Sticky timeout flag; an abort beats a simultaneous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        err_q <= 1'b0;
    else if (abort)   err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign ext.ext_cs    = cs;
  assign ext.ext_oe    = oe;
  assign ext.ext_we    = we;
  assign ext.ext_a     = adr_q;
  // Write data is only presented while a write access is on the bus.
  assign ext.ext_d_out = ((state_q == S_ACCESS) && dir_q) ? dat_q : 8'd0;

  assign ramdout     = rdata_q;
  assign out_en      = hit;
  // Gated by reset so the core is released even if it keeps its strobe up.
  assign cpuwait     = stall & nrst;
  assign timeout_err = err_q;

endmodule
